// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shifts, rotates, arithmetic shift, load,
// plus a self-timed burst mode that serialises a loaded word out of sout_r LSB-first.
module univ_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  // Priority is sclr, then an active burst, then the en/mode operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= RESET_VALUE;
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sclr) begin
        data_q  <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (en) begin
          data_q <= {1'b0, data_q[WIDTH-1:1]};
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end else if (en) begin
        case (mode)
          3'b000: data_q <= data_q;
          3'b001: data_q <= {data_q[WIDTH-2:0], sin_r};
          3'b010: data_q <= {sin_l, data_q[WIDTH-1:1]};
          3'b011: data_q <= d;
          3'b100: data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          3'b101: data_q <= {data_q[0], data_q[WIDTH-1:1]};
          3'b110: data_q <= {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          default: begin
            data_q  <= d;
            cnt_q   <= '0;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign q      = data_q;
  assign sout_r = data_q[0];
  assign sout_l = data_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RESET_VALUE=8'h3C).
module tb_univ_shift_reg;

  logic       clk;
  logic       reset;
  logic       sclr;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int testsRun = 0;
  int testsFailed = 0;

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut (
    .clk(clk), .reset(reset), .sclr(sclr), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before anything is sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] bits;
    reset = 1'b0; sclr = 1'b0; en = 1'b0; mode = 3'b000;
    d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

    #7;
    checkOutput("reset_q", q, 8'h3C);
    checkOutput("reset_busy", {7'b0, busy}, 8'h00);
    checkOutput("reset_done", {7'b0, done}, 8'h00);
    #5 reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("idle_q", q, 8'h3C);
      checkOutput("idle_busy", {7'b0, busy}, 8'h00);
      checkOutput("idle_done", {7'b0, done}, 8'h00);
    end

    en = 1'b1; mode = 3'b011; d = 8'hA5;
    applyStimulus(); checkOutput("load", q, 8'hA5);
    mode = 3'b001; sin_r = 1'b1;
    applyStimulus(); checkOutput("shl", q, 8'h4B);
    mode = 3'b100;
    applyStimulus(); checkOutput("rotl", q, 8'h96);
    mode = 3'b110;
    applyStimulus(); checkOutput("ashr", q, 8'hCB);
    mode = 3'b010; sin_l = 1'b0;
    applyStimulus(); checkOutput("shr", q, 8'h65);
    mode = 3'b101;
    applyStimulus(); checkOutput("rotr", q, 8'hB2);
    checkOutput("sout_r", {7'b0, sout_r}, 8'h00);
    checkOutput("sout_l", {7'b0, sout_l}, 8'h01);
    mode = 3'b000;
    applyStimulus(); checkOutput("hold", q, 8'hB2);
    en = 1'b0; mode = 3'b011; d = 8'h00;
    applyStimulus(); checkOutput("en_off", q, 8'hB2);

    // Plain burst; the load request on the following cycles must be ignored.
    en = 1'b1; mode = 3'b111; d = 8'hA5;
    applyStimulus();
    mode = 3'b011; d = 8'hFF;
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      checkOutput("burst1_sout", {7'b0, sout_r}, {7'b0, bits[i]});
      checkOutput("burst1_busy", {7'b0, busy}, 8'h01);
      checkOutput("burst1_nodone", {7'b0, done}, 8'h00);
      applyStimulus();
    end
    checkOutput("burst1_done", {7'b0, done}, 8'h01);
    checkOutput("burst1_idle", {7'b0, busy}, 8'h00);
    checkOutput("burst1_q", q, 8'h00);
    en = 1'b0;
    applyStimulus();
    checkOutput("burst1_pulse", {7'b0, done}, 8'h00);

    // Burst with a two-cycle stall after the third shift.
    en = 1'b1; mode = 3'b111; d = 8'hF0;
    applyStimulus();
    bits = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("stall_sout", {7'b0, sout_r}, {7'b0, bits[i]});
      checkOutput("stall_nodone", {7'b0, done}, 8'h00);
      applyStimulus();
      if (i == 2) begin
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
          applyStimulus();
          checkOutput("stall_q", q, 8'h1E);
          checkOutput("stall_sout_hold", {7'b0, sout_r}, 8'h00);
          checkOutput("stall_busy", {7'b0, busy}, 8'h01);
          checkOutput("stall_done", {7'b0, done}, 8'h00);
        end
        en = 1'b1;
      end
    end
    checkOutput("stall_done_end", {7'b0, done}, 8'h01);
    checkOutput("stall_q_end", q, 8'h00);
    en = 1'b0;
    applyStimulus();

    // sclr abort after four shifts.
    en = 1'b1; mode = 3'b111; d = 8'hC3;
    applyStimulus();
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("sclr_pre_q", q, 8'h0C);
    sclr = 1'b1;
    applyStimulus();
    sclr = 1'b0; en = 1'b0;
    checkOutput("sclr_q", q, 8'h00);
    checkOutput("sclr_busy", {7'b0, busy}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      checkOutput("sclr_nodone", {7'b0, done}, 8'h00);
      applyStimulus();
    end

    // Asynchronous reset abort between edges.
    en = 1'b1; mode = 3'b111; d = 8'hC3;
    applyStimulus();
    for (int i = 0; i < 4; i++) applyStimulus();
    #3 reset = 1'b0;
    #1;
    checkOutput("areset_q", q, 8'h3C);
    checkOutput("areset_busy", {7'b0, busy}, 8'h00);
    checkOutput("areset_done", {7'b0, done}, 8'h00);
    #1 reset = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("areset_nodone", {7'b0, done}, 8'h00);
      checkOutput("areset_hold", q, 8'h3C);
    end

    // Back-to-back bursts: the second starts in the done cycle of the first.
    en = 1'b1; mode = 3'b111; d = 8'hA5;
    applyStimulus();
    d = 8'h81;
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      checkOutput("b2b1_sout", {7'b0, sout_r}, {7'b0, bits[i]});
      checkOutput("b2b1_nodone", {7'b0, done}, 8'h00);
      applyStimulus();
    end
    checkOutput("b2b1_done", {7'b0, done}, 8'h01);
    applyStimulus();
    mode = 3'b000;
    checkOutput("b2b2_start_done", {7'b0, done}, 8'h00);
    checkOutput("b2b2_start_busy", {7'b0, busy}, 8'h01);
    checkOutput("b2b2_start_q", q, 8'h81);
    bits = 8'h81;
    for (int i = 0; i < 8; i++) begin
      checkOutput("b2b2_sout", {7'b0, sout_r}, {7'b0, bits[i]});
      checkOutput("b2b2_nodone", {7'b0, done}, 8'h00);
      applyStimulus();
    end
    checkOutput("b2b2_done", {7'b0, done}, 8'h01);
    checkOutput("b2b2_q", q, 8'h00);
    en = 1'b0;
    applyStimulus();
    checkOutput("b2b2_pulse", {7'b0, done}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
